sub_seq_ctrl: RTL and testbench

SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

---
 rtl/sub_seq_ctrl_if.sv | 28 ++
 rtl/sub_seq_ctrl.sv | 111 +++++++++++
 tb/tb_sub_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_seq_ctrl_if.sv
// Handshake/result bundle for the nibble-serial subtractor.
// start is taken on a clock edge whenever busy is low; done pulses for one cycle with d/bout/zero valid.
interface sub_seq_ctrl_if #(
  parameter int N_NIB = 4
);
  localparam int W = 4 * N_NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         zero;
  logic [1:0]   dbg_state;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, zero, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, zero, dbg_state
  );
endinterface

// File: rtl/sub_seq_ctrl.sv
// Nibble-serial subtractor: one shared 4-bit borrow slice walks LSB to MSB,
// producing d = a - b - bin (mod 2^W), the final borrow and a zero flag.
module sub_seq_ctrl #(
  parameter int N_NIB = 4
) (
  input  logic           clk,
  input  logic           rst,
  sub_seq_ctrl_if.slave  bus
);
  localparam int W     = 4 * N_NIB;
  localparam int IDX_W = $clog2(N_NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    a_nib    = 4'h0;
    b_nib    = 4'h0;

    for (int i = 0; i < N_NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
    // Bit 4 of the 5-bit difference is the borrow out of this nibble.
    slice = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < N_NIB; i++) begin
          if (idx_q == IDX_W'(i)) diff_d[i*4 +: 4] = slice[3:0];
        end
        borrow_d = slice[4];
        if (idx_q == IDX_W'(N_NIB - 1)) begin
          bout_d  = slice[4];
          zero_d  = (diff_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.d         = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Bench for sub_seq_ctrl (N_NIB=4): directed vector table, hand-written corner
// sequences and random operands scored against an arithmetic reference.
module tb_sub_seq_ctrl;
  localparam int N_NIB = 4;
  localparam int W     = 4 * N_NIB;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [W+1:0] exp_q[$];
  int           due_q[$];

  sub_seq_ctrl_if #(.N_NIB(N_NIB)) bus ();

  sub_seq_ctrl #(.N_NIB(N_NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
  } vec_t;

  vec_t vecs[10];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bin);
    logic [W:0]   full;
    logic [W-1:0] dd;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    dd   = full[W-1:0];
    return {full[W], (dd == '0), dd};
  endfunction

  // scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          logic [W+1:0] e;
          int           due;
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          check("result_d", 32'(bus.d), 32'(e[W-1:0]));
          check("result_bout", {31'd0, bus.bout}, {31'd0, e[W+1]});
          check("result_zero", {31'd0, bus.zero}, {31'd0, e[W]});
          check("done_latency", cyc, due);
        end
      end
    end
  end

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W+1:0] exp, input bit track);
    int guard;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check("wait_not_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk); #1;
    if (track) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + N_NIB);
    end
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 65535));
    bus.b     = W'($urandom_range(0, 65535));
    bus.bin   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};

    // reset state
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_d", 32'(bus.d), 32'd0);
    check("reset_bout", 32'(bus.bout), 32'd0);
    check("reset_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed table: busy for N_NIB cycles then a one-cycle done
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].bin, {vecs[v].bout, vecs[v].zero, vecs[v].d}, 1'b1);
      for (int c = 0; c < N_NIB; c++) begin
        @(negedge clk);
        check("busy_during_run", 32'(bus.busy), 32'd1);
      end
      @(negedge clk);
      check("done_after_run", 32'(bus.done), 32'd1);
      @(posedge clk); #1;
    end
    drain();

    // result holds through idle
    idle_cycles(3);
    check("hold_d", 32'(bus.d), 32'(vecs[9].d));
    check("hold_bout", 32'(bus.bout), 32'(vecs[9].bout));
    check("hold_done_low", 32'(bus.done), 32'd0);

    // start held high with operands changing every cycle
    bus.start = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j <= N_NIB; j++) begin
        ra   = W'($urandom_range(0, 65535));
        rb   = W'($urandom_range(0, 65535));
        rbin = 1'($urandom_range(0, 1));
        bus.a   = ra;
        bus.b   = rb;
        bus.bin = rbin;
        @(posedge clk); #1;
        if (j == 0) begin
          exp_q.push_back(ref_model(ra, rb, rbin));
          due_q.push_back(cyc + N_NIB);
        end
      end
    end
    bus.start = 1'b0;
    drain();
    idle_cycles(2);

    // asynchronous reset in the third run cycle aborts without done
    run_op(16'h1234, 16'h0234, 1'b0, ref_model(16'h1234, 16'h0234, 1'b0), 1'b1);
    drain();
    run_op(16'h5555, 16'h1111, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_d", 32'(bus.d), 32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    check("abort_zero", 32'(bus.zero), 32'd0);
    #2;
    rst = 1'b0;
    idle_cycles(6);
    check("after_abort_d", 32'(bus.d), 32'd0);
    run_op(16'h0010, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h000F}, 1'b1);
    drain();

    // random operands, mixed back-to-back and gapped
    for (int k = 0; k < 1000; k++) begin
      ra   = W'($urandom_range(0, 65535));
      rb   = ($urandom_range(0, 15) == 0) ? ra : W'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, ref_model(ra, rb, rbin), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 7));
    end
    drain();
    idle_cycles(8);
    check("no_pending_results", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
